icache_fill_arbiter: RTL and testbench

//  Shares one instruction-side RAM read port between NREQ per-core icache fill requesters
//  (multicore build: one icache per core). Round-robin arbitration, one outstanding fill at a time.

---
 rtl/cpu_types_pkg.sv | 6 +
 rtl/icache_fill_arbiter_rr_priority.sv | 21 ++
 rtl/icache_fill_arbiter.sv | 69 ++++++
 tb/tb_icache_fill_arbiter.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg: shared CPU/RAM handshake types and the fill-arbiter state encoding
package cpu_types_pkg;
   typedef logic [31:0] word_t;
   typedef enum logic [1:0] {FREE, BUSY, ACCESS, ERROR} ramstate_t;
   typedef enum logic {ARB_IDLE, ARB_FILL} arb_state_t;
endpackage

// File: rtl/icache_fill_arbiter_rr_priority.sv
// rr_priority: combinational round-robin picker, first set req bit scanning upward from ptr
module rr_priority #(
   parameter int NREQ = 2,
   localparam int PW = $clog2(NREQ)
) (
   input  logic [NREQ-1:0] req,
   input  logic [PW-1:0]   ptr,
   output logic            valid,
   output logic [PW-1:0]   idx
);
   always_comb begin
      valid = 1'b0;
      idx = '0;
      for (int i = NREQ - 1; i >= 0; i--) begin
         if (req[(int'(ptr) + i) % NREQ]) begin
            valid = 1'b1;
            idx = PW'((int'(ptr) + i) % NREQ);
         end
      end
   end
endmodule

// File: rtl/icache_fill_arbiter.sv
// icache_fill_arbiter: round-robin sharing of one RAM read port between NREQ icache fill requesters
module icache_fill_arbiter
   import cpu_types_pkg::*;
#(
   parameter int NREQ   = 2,
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic                   CLK,
   input  logic                   RST,
   input  logic [NREQ-1:0]        iREN,
   input  logic [NREQ*ADDR_W-1:0] iaddr,
   output logic [NREQ-1:0]        iwait,
   output logic [NREQ*DATA_W-1:0] iload,
   output logic                   ramREN,
   output logic [ADDR_W-1:0]      ramaddr,
   input  logic [DATA_W-1:0]      ramload,
   input  ramstate_t              ramstate
);
   localparam int PW = $clog2(NREQ);
   arb_state_t state_q, state_d;
   logic [PW-1:0] rr_ptr_q, rr_ptr_d, grant_q, grant_d, pick;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic pick_valid, done;
   rr_priority #(.NREQ(NREQ)) u_pick (.req(iREN), .ptr(rr_ptr_q), .valid(pick_valid), .idx(pick));
   // a dropped request kills the fill even if ACCESS arrives in the same cycle
   assign done = (state_q == ARB_FILL) && iREN[grant_q] && (ramstate == ACCESS);
   always_comb begin
      state_d = state_q;
      rr_ptr_d = rr_ptr_q;
      grant_d = grant_q;
      addr_d = addr_q;
      if (state_q == ARB_IDLE) begin
         if (pick_valid) begin
            state_d = ARB_FILL;
            grant_d = pick;
            addr_d = iaddr[pick*ADDR_W +: ADDR_W];
         end
      end else if (!iREN[grant_q]) begin
         state_d = ARB_IDLE;
      end else if (done) begin
         state_d = ARB_IDLE;
         rr_ptr_d = (grant_q == PW'(NREQ - 1)) ? '0 : grant_q + 1'b1;
      end
   end
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q <= ARB_IDLE;
         rr_ptr_q <= '0;
         grant_q <= '0;
         addr_q <= '0;
      end else begin
         state_q <= state_d;
         rr_ptr_q <= rr_ptr_d;
         grant_q <= grant_d;
         addr_q <= addr_d;
      end
   end
   always_comb begin
      ramREN = (state_q == ARB_FILL);
      ramaddr = ramREN ? addr_q : '0;
      iwait = '1;
      iload = '0;
      iwait[grant_q] = ~done;
      iload[grant_q*DATA_W +: DATA_W] = done ? ramload : '0;
   end
   a_addr_stable: assert property (@(posedge CLK) disable iff (RST)
      (state_q == ARB_FILL && iREN[grant_q]) |-> (iaddr[grant_q*ADDR_W +: ADDR_W] == addr_q));
endmodule

// File: tb/tb_icache_fill_arbiter.sv
// tb_icache_fill_arbiter: directed stimulus, per-cycle model comparison plus literal expectations
module tb_icache_fill_arbiter;
   import cpu_types_pkg::*;
   localparam int N = 2, AW = 32, DW = 32;
   logic CLK = 1'b0, RST = 1'b1;
   logic [N-1:0] iREN = '0;
   logic [N*AW-1:0] iaddr = '0;
   logic [N-1:0] iwait;
   logic [N*DW-1:0] iload;
   logic ramREN;
   logic [AW-1:0] ramaddr;
   logic [DW-1:0] ramload = '0;
   ramstate_t ramstate = FREE;
   int checks = 0, errors = 0;
   always #5 CLK = ~CLK;
   icache_fill_arbiter #(.NREQ(N), .ADDR_W(AW), .DATA_W(DW)) dut (
      .CLK(CLK), .RST(RST), .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
      .ramREN(ramREN), .ramaddr(ramaddr), .ramload(ramload), .ramstate(ramstate));
   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %h want %h", nm, act, exp);
      end
   endtask
   task automatic cyc();
      @(posedge CLK);
      #1;
   endtask
   // model: who owns the RAM, which address, and whose turn it is next
   bit m_busy = 1'b0;
   int m_own = 0, m_ptr = 0;
   logic [AW-1:0] m_addr = '0;
   always @(posedge CLK or posedge RST) begin
      if (RST) begin
         m_busy = 1'b0; m_own = 0; m_ptr = 0; m_addr = '0;
      end else if (!m_busy) begin
         for (int k = 0; k < N; k++)
            if (!m_busy && iREN[(m_ptr + k) % N]) begin
               m_busy = 1'b1;
               m_own = (m_ptr + k) % N;
               m_addr = iaddr[m_own*AW +: AW];
            end
      end else if (!iREN[m_own]) begin
         m_busy = 1'b0;
      end else if (ramstate == ACCESS) begin
         m_busy = 1'b0;
         m_ptr = (m_own + 1) % N;
      end
   end
   logic m_done;
   logic [N-1:0] e_wait;
   logic [N*DW-1:0] e_load;
   int dp [N] = '{0, 0};
   always @(negedge CLK) begin
      m_done = m_busy && iREN[m_own] && ramstate == ACCESS;
      e_wait = '1;
      e_load = '0;
      for (int r = 0; r < N; r++)
         if (m_done && r == m_own) begin
            e_wait[r] = 1'b0;
            e_load[r*DW +: DW] = ramload;
         end
      chk("m_ramREN", ramREN, m_busy);
      chk("m_ramaddr", ramaddr, m_busy ? m_addr : '0);
      chk("m_iwait", iwait, e_wait);
      chk("m_iload", iload, e_load);
      for (int r = 0; r < N; r++) if (!iwait[r]) dp[r]++;
   end
   logic [1:0] pat [8];
   initial begin
      pat = '{2'b11, 2'b10, 2'b11, 2'b01, 2'b11, 2'b10, 2'b11, 2'b01};
      iaddr = {32'h0000_0200, 32'h0000_0040};
      repeat (2) @(posedge CLK);
      #1;
      @(negedge CLK);
      chk("rst_ramREN", ramREN, 0);
      chk("rst_iwait", iwait, 2'b11);
      chk("rst_iload", iload, 0);
      RST = 1'b0;
      cyc();
      iREN = 2'b01; ramstate = BUSY; ramload = 32'h2001_0004;
      @(negedge CLK); chk("s_idle_ren", ramREN, 0);
      cyc();
      repeat (3) begin
         @(negedge CLK);
         chk("s_busy_addr", ramaddr, 32'h40);
         chk("s_busy_wait", iwait, 2'b11);
         cyc();
      end
      ramstate = ACCESS;
      @(negedge CLK);
      chk("s_wait", iwait, 2'b10);
      chk("s_load0", iload[31:0], 32'h2001_0004);
      chk("s_load1", iload[63:32], 0);
      cyc(); iREN = 2'b00; ramstate = BUSY;
      @(negedge CLK);
      chk("s_after_wait", iwait, 2'b11);
      chk("s_after_ren", ramREN, 0);
      iREN = 2'b10;
      cyc();
      @(negedge CLK);
      chk("a_addr", ramaddr, 32'h200);
      chk("a_ren", ramREN, 1);
      cyc(); iREN = 2'b00; ramstate = ACCESS;
      @(negedge CLK);
      chk("a_nopulse", iwait, 2'b11);
      chk("a_ren_drop", ramREN, 1);
      cyc(); ramstate = BUSY;
      @(negedge CLK); chk("a_idle", ramREN, 0);
      iREN = 2'b11; ramstate = ACCESS; ramload = 32'h1111_2222;
      cyc();
      @(negedge CLK);
      chk("a_tie_wait", iwait, 2'b01);
      chk("a_tie_load", iload[63:32], 32'h1111_2222);
      chk("a_tie_addr", ramaddr, 32'h200);
      cyc(); iREN = 2'b00;
      iaddr[31:0] = 32'h80; iREN = 2'b01;
      cyc();
      for (int k = 0; k < 3; k++) begin
         ramstate = (k == 2) ? ACCESS : ERROR;
         @(negedge CLK);
         chk("e_ren", ramREN, 1);
         chk("e_addr", ramaddr, 32'h80);
         chk("e_wait", iwait, (k == 2) ? 2'b10 : 2'b11);
         cyc();
      end
      iREN = 2'b00; ramstate = BUSY;
      @(negedge CLK); chk("e_idle", ramREN, 0);
      iREN = 2'b01;
      cyc();
      @(negedge CLK); chk("r_fill", ramREN, 1);
      cyc();
      #1 RST = 1'b1;
      #1;
      chk("r_ren", ramREN, 0);
      chk("r_wait", iwait, 2'b11);
      chk("r_addr", ramaddr, 0);
      iREN = 2'b00;
      #1 RST = 1'b0;
      cyc();
      @(negedge CLK); chk("r_idle", ramREN, 0);
      cyc();
      iREN = 2'b11; ramstate = ACCESS; ramload = 32'hABCD_0000;
      for (int c = 0; c < 8; c++) begin
         @(negedge CLK);
         chk("c_wait", iwait, pat[c]);
         if (c % 2 == 1) chk("c_addr", ramaddr, (c % 4 == 1) ? 32'h80 : 32'h200);
         cyc();
      end
      iREN = 2'b00; ramstate = FREE;
      @(negedge CLK); chk("c_end", ramREN, 0);
      chk("pulses0", dp[0], 4);
      chk("pulses1", dp[1], 3);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
